lcd_read_ctrl: RTL and testbench

HD44780-style LCD read-cycle engine: the read direction of the display_to_lcd interface, complementing the existing command/data write path. On request it drives RS/RW/E through a full read bus cycle, samples DB[7:0] and returns the byte. It can optionally re-poll the busy flag until it clears. It sits beside the write sequencer; the top level muxes LCD control pins to this block while `busy`=1.

---
 rtl/lcd_read_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_read_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_ctrl.sv
// HD44780-style LCD read-cycle engine: drives RS/RW/E through a read bus cycle,
// samples DB[7:0], optionally re-polls the busy flag. Option: LCD_READ_CTRL_TIMEOUT_EN.
module lcd_read_ctrl #(
   parameter int unsigned SETUP_CYCLES    = 1,
   parameter int unsigned E_HIGH_CYCLES   = 2,
   parameter int unsigned HOLD_CYCLES     = 1,
   parameter int unsigned POLL_GAP_CYCLES = 4,
   parameter logic [15:0] TIMEOUT_POLLS   = 16'd3125
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rs_in,
   input  logic       poll,
   input  logic [7:0] lcd_db_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       timeout,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_EHI   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Down-counter load values: a state lasts (load + 1) cycles.
   localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] EHI_LOAD   = 8'(E_HIGH_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(POLL_GAP_CYCLES - 1);

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        rs_r, rs_s;
   logic        poll_r, poll_s;
   logic        accept_s;
   logic        sample_s;
   logic        timeout_s;
   logic [7:0]  rd_data_r;
   logic        busy_r, done_r, lcd_rs_r, lcd_rw_r, lcd_e_r;
   logic        busy_s, done_s, lcd_rs_s, lcd_rw_s, lcd_e_s;

`ifdef LCD_READ_CTRL_TIMEOUT_EN
   logic [15:0] poll_cnt_r;
   logic        timeout_r;
`endif

   // Next-state, counter and transaction-latch logic.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      rs_s      = rs_r;
      poll_s    = poll_r;
      accept_s  = 1'b0;
      sample_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               state_s  = ST_SETUP;
               cnt_s    = SETUP_LOAD;
               rs_s     = rs_in;
               poll_s   = poll & ~rs_in;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == 8'd0) begin
               state_s = ST_EHI;
               cnt_s   = EHI_LOAD;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_EHI: begin
            if (cnt_r == 8'd0) begin
               sample_s = 1'b1;
               state_s  = ST_HOLD;
               cnt_s    = HOLD_LOAD;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_HOLD: begin
            // rd_data_r already holds the byte sampled at the end of EHI.
            if (cnt_r != 8'd0) begin
               cnt_s = cnt_r - 8'd1;
            end else if (poll_r && rd_data_r[7]) begin
`ifdef LCD_READ_CTRL_TIMEOUT_EN
               if (poll_cnt_r >= TIMEOUT_POLLS) begin
                  state_s   = ST_DONE;
                  timeout_s = 1'b1;
               end else begin
                  state_s = ST_GAP;
                  cnt_s   = GAP_LOAD;
               end
`else
               state_s = ST_GAP;
               cnt_s   = GAP_LOAD;
`endif
            end else begin
               state_s = ST_DONE;
            end
         end
         ST_GAP: begin
            if (cnt_r == 8'd0) begin
               state_s = ST_SETUP;
               cnt_s   = SETUP_LOAD;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the pins come straight from flops.
   always_comb begin
      busy_s   = 1'b0;
      done_s   = 1'b0;
      lcd_rs_s = 1'b0;
      lcd_rw_s = 1'b0;
      lcd_e_s  = 1'b0;
      case (state_s)
         ST_SETUP, ST_EHI, ST_HOLD, ST_GAP: begin
            busy_s   = 1'b1;
            lcd_rs_s = rs_s;
            lcd_rw_s = 1'b1;
            lcd_e_s  = (state_s == ST_EHI);
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, latches and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 8'd0;
         rs_r      <= 1'b0;
         poll_r    <= 1'b0;
         rd_data_r <= 8'h00;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         lcd_rs_r  <= 1'b0;
         lcd_rw_r  <= 1'b0;
         lcd_e_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         rs_r     <= rs_s;
         poll_r   <= poll_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         lcd_rs_r <= lcd_rs_s;
         lcd_rw_r <= lcd_rw_s;
         lcd_e_r  <= lcd_e_s;
         if (sample_s) begin
            rd_data_r <= lcd_db_in;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

`ifdef LCD_READ_CTRL_TIMEOUT_EN
   // Busy-read counter and the timeout pulse that rides with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         poll_cnt_r <= 16'd0;
         timeout_r  <= 1'b0;
      end else begin
         timeout_r <= timeout_s;
         if (accept_s) begin
            poll_cnt_r <= 16'd0;
         end else if (sample_s && poll_r && lcd_db_in[7]) begin
            poll_cnt_r <= poll_cnt_r + 16'd1;
         end else begin
            poll_cnt_r <= poll_cnt_r;
         end
      end
   end
   assign timeout = timeout_r;
`else
   assign timeout = timeout_s & accept_s;
`endif

   assign busy    = busy_r;
   assign done    = done_r;
   assign rd_data = rd_data_r;
   assign lcd_rs  = lcd_rs_r;
   assign lcd_rw  = lcd_rw_r;
   assign lcd_e   = lcd_e_r;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Self-checking bench for lcd_read_ctrl: directed and randomized reads checked
// against a timing-formula reference model.
module tb_lcd_read_ctrl;

   localparam int S = 1;
   localparam int E = 2;
   localparam int H = 1;
   localparam int G = 4;
`ifdef LCD_READ_CTRL_TIMEOUT_EN
   localparam int TP = 3;
`else
   localparam int TP = 1000000;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       rs_in = 1'b0;
   logic       poll = 1'b0;
   logic [7:0] lcd_db_in = 8'h00;
   logic       busy, done, timeout, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] rd_data;

   int total = 0;
   int bad = 0;
   logic [7:0] data_q[$];

   lcd_read_ctrl #(
      .SETUP_CYCLES(S), .E_HIGH_CYCLES(E), .HOLD_CYCLES(H),
      .POLL_GAP_CYCLES(G), .TIMEOUT_POLLS(16'd3)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rs_in(rs_in), .poll(poll),
      .lcd_db_in(lcd_db_in), .busy(busy), .done(done), .rd_data(rd_data),
      .timeout(timeout), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One read transaction: data_q holds the byte presented for each E pulse.
   // The model derives pulse count and the cycle-by-cycle waveform from the
   // timing rules (period S+E+H+G per poll, done one cycle after last HOLD).
   task automatic run_read(input bit rs, input bit pl, input bit extra_start);
      int pulses, d, per, j, rel, first_clear;
      bit eff_poll, exp_to, exp_e;
      logic [7:0] last;
      eff_poll = pl && !rs;
      pulses = 1;
      exp_to = 1'b0;
      if (eff_poll) begin
         first_clear = data_q.size() - 1;
         for (int i = data_q.size() - 1; i >= 0; i--)
            if (!data_q[i][7]) first_clear = i;
         pulses = first_clear + 1;
         if (first_clear >= TP) begin
            pulses = TP;
            exp_to = 1'b1;
         end
      end
      per  = S + E + H + G;
      d    = pulses * (S + E + H) + (pulses - 1) * G + 1;
      last = data_q[pulses - 1];
      // cycle N: present the request
      @(negedge clk);
      start = 1'b1; rs_in = rs; poll = pl; lcd_db_in = data_q[0];
      for (int o = 1; o <= d + 1; o++) begin
         @(negedge clk);
         start = extra_start && (o == 2 || o == d);
         j   = (o - 1) / per;
         rel = (o - 1) - j * per;
         if (rel == 0 && j >= 1 && j < data_q.size()) lcd_db_in = data_q[j];
         exp_e = (o < d) && (j < pulses) && (rel >= S) && (rel < S + E);
         check($sformatf("lcd_e@%0d", o), lcd_e, exp_e);
         check($sformatf("lcd_rw@%0d", o), lcd_rw, o < d);
         check($sformatf("lcd_rs@%0d", o), lcd_rs, rs && (o < d));
         check($sformatf("busy@%0d", o), busy, o <= d);
         check($sformatf("done@%0d", o), done, o == d);
         check($sformatf("timeout@%0d", o), timeout, exp_to && (o == d));
         if (o == d) check("rd_data", rd_data, last);
      end
      start = 1'b0;
   endtask

   initial begin
      int k, pulses_seen, done_seen;
      bit rs_r, pl_r;
      logic prev_e;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_rs", lcd_rs, 1'b0);
      check("rst_rw", lcd_rw, 1'b0);
      check("rst_e", lcd_e, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      reset = 1'b0;
      @(negedge clk);

      // single data read
      data_q = '{8'hA5};
      run_read(1'b1, 1'b0, 1'b0);
      // busy poll with three busy reads
      data_q = '{8'h80, 8'h80, 8'h80, 8'h12};
      run_read(1'b0, 1'b1, 1'b0);
      // poll ignored for data reads
      data_q = '{8'hFF};
      run_read(1'b1, 1'b1, 1'b0);
      // start during busy and in the done cycle is ignored
      data_q = '{8'h5A};
      run_read(1'b1, 1'b0, 1'b1);

      // reset mid-pulse: previous rd_data is 8'h5A, must clear
      @(negedge clk);
      start = 1'b1; rs_in = 1'b1; poll = 1'b0; lcd_db_in = 8'h3C;
      @(negedge clk); start = 1'b0;            // N+1
      @(negedge clk);                           // N+2
      @(negedge clk);                           // N+3
      check("pre_reset_e", lcd_e, 1'b1);
      reset = 1'b1;
      @(negedge clk);                           // N+4
      reset = 1'b0;
      check("mid_rst_e", lcd_e, 1'b0);
      check("mid_rst_rw", lcd_rw, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rd_data", rd_data, 8'h00);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 0);

`ifdef LCD_READ_CTRL_TIMEOUT_EN
      data_q = '{8'h80, 8'h80, 8'h80, 8'h80};
      run_read(1'b0, 1'b1, 1'b0);
`else
      // endless polling without the timeout feature
      @(negedge clk);
      start = 1'b1; rs_in = 1'b0; poll = 1'b1; lcd_db_in = 8'h80;
      pulses_seen = 0; done_seen = 0; prev_e = 1'b0;
      for (int o = 1; o <= 101 * (S + E + H + G); o++) begin
         @(negedge clk);
         start = 1'b0;
         if (lcd_e && !prev_e) pulses_seen++;
         if (done) done_seen++;
         prev_e = lcd_e;
      end
      check("endless_pulses", pulses_seen, 101);
      check("endless_no_done", done_seen, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
`endif

      // randomized transactions
      for (int t = 0; t < 16; t++) begin
         rs_r = 1'($urandom_range(0, 1));
         pl_r = 1'($urandom_range(0, 1));
         data_q = {};
         if (pl_r && !rs_r) begin
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) data_q.push_back(8'($urandom) | 8'h80);
            data_q.push_back(8'($urandom) & 8'h7F);
         end else begin
            data_q.push_back(8'($urandom));
         end
         run_read(rs_r, pl_r, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
